// File: rtl/ddr2_test_pkg.sv
// Definitions shared by the DDR2 board-test pattern writer and read checker:
// default widths, the test data pattern and the checker state encoding.
package ddr2_test_pkg;

  localparam int DEF_ADDR_WIDTH = 26;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_DATA,
    ST_DONE
  } chk_state_t;

  // Word w carries its own low 16 index bits, inverted copy in the upper half.
  function automatic logic [31:0] pat(input logic [15:0] w);
    return {~w, w};
  endfunction

endpackage

// File: rtl/ddr2_pat_cmp.sv
// One-stage registered compare of a returned read beat against the test pattern.
module ddr2_pat_cmp
  import ddr2_test_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] word_idx,
  output logic                  mis,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  logic [DATA_WIDTH-1:0] exp_p0;
  logic                  mis_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;

  assign exp_p0 = DATA_WIDTH'(pat(word_idx[15:0]));

  // p0 -> p1: register compare result and the word it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_p1 <= 1'b0;
    end else begin
      mis_p1 <= vld && (data != exp_p0);
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= word_idx;
  end

  assign mis      = mis_p1;
  assign err_addr = addr_p1;

endmodule

// File: rtl/ddr2_rd_checker.sv
// DDR2 board-test reader: after init and writer completion, reads back all test
// words in bursts and flags any beat that differs from the writer's pattern.
module ddr2_rd_checker
  import ddr2_test_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RBURST_LEN = 8,
  parameter int TEST_WORDS = 1024,
  parameter int RD_DELAY   = 2000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  init_end,
  input  logic                  wr_over,
  output logic                  rd_req,
  input  logic                  rd_ack,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_burst_len,
  input  logic                  rd_data_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic                  rd_error,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int CNT_W = (RD_DELAY > 1) ? $clog2(RD_DELAY) : 1;
  localparam logic [CNT_W-1:0]      DELAY_LAST = CNT_W'(RD_DELAY - 1);
  localparam logic [7:0]            LAST_BEAT  = 8'(RBURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_BASE  = ADDR_WIDTH'(TEST_WORDS - RBURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(RBURST_LEN);

  chk_state_t            state, state_nxt;
  logic [CNT_W-1:0]      dly_cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic [7:0]            beat_cnt;
  logic                  beat_take, beat_last, proto_err;
  logic [ADDR_WIDTH-1:0] word_idx_p0;
  logic                  mis_p1;
  logic [ADDR_WIDTH-1:0] mis_addr_p1;
  logic                  err_q;
  logic [15:0]           cnt_q, cnt_nxt;
  logic [ADDR_WIDTH-1:0] first_q;
  logic                  first_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  // A beat is legal in DATA, or in REQ when it rides on the accepting ack.
  assign beat_take = rd_data_vld && (((state == ST_REQ) && rd_ack) || (state == ST_DATA));
  assign beat_last = beat_take && (beat_cnt == LAST_BEAT);
  assign proto_err = (rd_data_vld && !beat_take) || (rd_ack && !rd_req);
  assign word_idx_p0 = base + ADDR_WIDTH'(beat_cnt);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    chk_busy  = 1'b0;
    chk_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_end && wr_over) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        chk_busy = 1'b1;
        if (dly_cnt == DELAY_LAST) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        chk_busy = 1'b1;
        rd_req   = 1'b1;
        if (rd_ack) begin
          if (beat_last) state_nxt = (base == LAST_BASE) ? ST_DONE : ST_REQ;
          else           state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        chk_busy = 1'b1;
        if (beat_last) state_nxt = (base == LAST_BASE) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        chk_done = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dly_cnt  <= '0;
      base     <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == ST_IDLE)      dly_cnt <= '0;
      else if (state == ST_WAIT) dly_cnt <= dly_cnt + CNT_W'(1);
      if (beat_take)             beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
      else if (state == ST_REQ)  beat_cnt <= '0;
      if (beat_last && (base != LAST_BASE)) base <= base + BURST_STEP;
    end
  end

  ddr2_pat_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .vld      (beat_take),
    .data     (rd_data),
    .word_idx (word_idx_p0),
    .mis      (mis_p1),
    .err_addr (mis_addr_p1)
  );

  // p1: fold the registered compare into the sticky error state
  assign cnt_nxt   = sat_inc(cnt_q, mis_p1);
  assign first_hit = mis_p1 && (cnt_q == 16'd0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_q   <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      err_q <= err_q || mis_p1 || proto_err;
      cnt_q <= cnt_nxt;
      if (first_hit) first_q <= mis_addr_p1;
    end
  end

  assign rd_addr        = base;
  assign rd_burst_len   = 8'(RBURST_LEN);
  assign rd_error       = err_q || mis_p1;
  assign err_cnt        = cnt_nxt;
  assign first_err_addr = first_hit ? mis_addr_p1 : first_q;

endmodule

// File: tb/tb_ddr2_rd_checker.sv
// Bench for ddr2_rd_checker: a small memory model answers read bursts with the
// test pattern (optionally corrupted) and a word-level model predicts the flags.
module tb_ddr2_rd_checker;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int TW  = 64;
  localparam int DLY = 20;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          init_end = 1'b0;
  logic          wr_over = 1'b0;
  logic          rd_ack = 1'b0;
  logic          rd_data_vld = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_req, chk_busy, chk_done, rd_error;
  logic [AW-1:0] rd_addr, first_err_addr;
  logic [7:0]    rd_burst_len;
  logic [15:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  ddr2_rd_checker #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RBURST_LEN (BL),
    .TEST_WORDS (TW),
    .RD_DELAY   (DLY)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .init_end       (init_end),
    .wr_over        (wr_over),
    .rd_req         (rd_req),
    .rd_ack         (rd_ack),
    .rd_addr        (rd_addr),
    .rd_burst_len   (rd_burst_len),
    .rd_data_vld    (rd_data_vld),
    .rd_data        (rd_data),
    .chk_busy       (chk_busy),
    .chk_done       (chk_done),
    .rd_error       (rd_error),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  // Writer's pattern from plain arithmetic: high half = 65535 - (w mod 65536).
  function automatic logic [31:0] ref_pat(input int w);
    longint lo;
    lo = longint'(w) % 65536;
    return 32'((65535 - lo) * 65536 + lo);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    init_end = 1'b0;
    wr_over = 1'b0;
    rd_ack = 1'b0;
    rd_data_vld = 1'b0;
    rd_data = '0;
    repeat (3) tick();
    sys_rst = 1'b0;
  endtask

  // Memory model: answers each request after ack_lat cycles and streams BL beats.
  task automatic run_traffic(input bit same, input int ack_lat, input int bad0, input int bad1,
                             input bit spur, input bit drop, input int rst_burst,
                             output int nreq, output int exp_err, output int exp_first,
                             output int lat);
    int cyc, w;
    logic [31:0] d;
    nreq = 0; exp_err = 0; exp_first = -1; lat = -1;
    init_end = 1'b1;
    wr_over = 1'b1;
    cyc = 0;
    while (rd_req !== 1'b1 && cyc < DLY + 50) begin
      tick();
      cyc++;
      rd_data_vld = spur && (cyc == 5);
      if (drop && cyc == 3) begin
        init_end = 1'b0;
        wr_over = 1'b0;
      end
    end
    rd_data_vld = 1'b0;
    lat = cyc - 1;
    checks++;
    if (rd_req !== 1'b1) begin
      $display("FAIL first_req_timeout: rd_req=%b after %0d cycles, required 1", rd_req, cyc);
      errors++;
      return;
    end
    while (nreq * BL < TW) begin
      checks++;
      if (rd_addr !== AW'(nreq * BL)) begin
        $display("FAIL req_addr: burst %0d rd_addr=%0d required %0d", nreq, rd_addr, nreq * BL);
        errors++;
      end
      for (int k = 0; k < ack_lat; k++) begin
        tick();
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== AW'(nreq * BL)) begin
          $display("FAIL req_hold: burst %0d rd_req=%b rd_addr=%0d required 1/%0d",
                   nreq, rd_req, rd_addr, nreq * BL);
          errors++;
        end
      end
      rd_ack = 1'b1;
      if (!same) begin
        tick();
        rd_ack = 1'b0;
        checks++;
        if (rd_req !== 1'b0) begin
          $display("FAIL req_drop: burst %0d rd_req=%b required 0", nreq, rd_req);
          errors++;
        end
      end
      for (int beat = 0; beat < BL; beat++) begin
        w = nreq * BL + beat;
        d = (w == bad0 || w == bad1) ? 32'h0000_0000 : ref_pat(w);
        if (d != ref_pat(w)) begin
          exp_err++;
          if (exp_first < 0) exp_first = w;
        end
        rd_data_vld = 1'b1;
        rd_data = d;
        if (nreq == rst_burst && beat == 4) begin
          checks++;
          if (err_cnt !== 16'(exp_err) || chk_busy !== 1'b1) begin
            $display("FAIL pre_rst: err_cnt=%0d busy=%b required %0d/1", err_cnt, chk_busy, exp_err);
            errors++;
          end
          #2;
          sys_rst = 1'b1;
          #1;
          checks++;
          if ({rd_req, chk_busy, chk_done, rd_error} !== 4'b0000 || err_cnt !== 16'd0 ||
              first_err_addr !== '0 || rd_addr !== '0) begin
            $display("FAIL async_rst: req=%b busy=%b done=%b err=%b cnt=%0d first=%0d addr=%0d required all 0",
                     rd_req, chk_busy, chk_done, rd_error, err_cnt, first_err_addr, rd_addr);
            errors++;
          end
          rd_data_vld = 1'b0;
          rd_data = '0;
          tick();
          tick();
          sys_rst = 1'b0;
          return;
        end
        tick();
        if (same && beat == 0) begin
          rd_ack = 1'b0;
          checks++;
          if (rd_req !== 1'b0) begin
            $display("FAIL req_drop_same: burst %0d rd_req=%b required 0", nreq, rd_req);
            errors++;
          end
        end
      end
      rd_data_vld = 1'b0;
      rd_data = '0;
      nreq++;
      if (nreq * BL < TW) begin
        checks++;
        if (rd_req !== 1'b1) begin
          $display("FAIL burst_gap: after burst %0d rd_req=%b required 1", nreq - 1, rd_req);
          errors++;
          return;
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rd_req, chk_busy, chk_done, rd_error} !== 4'b0000 || err_cnt !== 16'd0 ||
        first_err_addr !== '0 || rd_addr !== '0 || rd_burst_len !== 8'(BL)) begin
      $display("FAIL reset_state: req=%b busy=%b done=%b err=%b cnt=%0d first=%0d addr=%0d blen=%0d required 0s, blen %0d",
               rd_req, chk_busy, chk_done, rd_error, err_cnt, first_err_addr, rd_addr, rd_burst_len, BL);
      errors++;
    end
    init_end = 1'b1;
    repeat (DLY + 10) tick();
    checks++;
    if (rd_req !== 1'b0 || chk_busy !== 1'b0) begin
      $display("FAIL idle_without_wr_over: rd_req=%b busy=%b required 0/0", rd_req, chk_busy);
      errors++;
    end
  endtask

  task automatic test_ack_no_req();
    do_reset();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    checks++;
    if (rd_error !== 1'b1 || err_cnt !== 16'd0 || chk_busy !== 1'b0) begin
      $display("FAIL ack_no_req: err=%b cnt=%0d busy=%b required 1/0/0", rd_error, err_cnt, chk_busy);
      errors++;
    end
  endtask

  task automatic check_end(input string name, input int nreq, input int exp_err, input int exp_first,
                           input bit exp_flag);
    checks++;
    if (nreq != TW / BL || chk_done !== 1'b1 || chk_busy !== 1'b0 || rd_req !== 1'b0) begin
      $display("FAIL %s_done: nreq=%0d done=%b busy=%b req=%b required %0d/1/0/0",
               name, nreq, chk_done, chk_busy, rd_req, TW / BL);
      errors++;
    end
    checks++;
    if (err_cnt !== 16'(exp_err) || rd_error !== exp_flag) begin
      $display("FAIL %s_errors: err_cnt=%0d rd_error=%b required %0d/%b",
               name, err_cnt, rd_error, exp_err, exp_flag);
      errors++;
    end
    checks++;
    if (first_err_addr !== AW'(exp_first < 0 ? 0 : exp_first)) begin
      $display("FAIL %s_first_addr: first_err_addr=%0d required %0d",
               name, first_err_addr, exp_first < 0 ? 0 : exp_first);
      errors++;
    end
  endtask

  task automatic test_golden();
    int nreq, ee, ef, lat;
    do_reset();
    run_traffic(1'b0, 3, -1, -1, 1'b0, 1'b0, -1, nreq, ee, ef, lat);
    checks++;
    if (lat != DLY) begin
      $display("FAIL first_req_latency: %0d cycles required %0d", lat, DLY);
      errors++;
    end
    check_end("golden", nreq, ee, ef, ee > 0);
    init_end = 1'b0;
    repeat (3) tick();
    init_end = 1'b1;
    repeat (DLY + 5) tick();
    checks++;
    if (chk_done !== 1'b1 || rd_req !== 1'b0 || chk_busy !== 1'b0) begin
      $display("FAIL done_hold: done=%b req=%b busy=%b required 1/0/0", chk_done, rd_req, chk_busy);
      errors++;
    end
  endtask

  task automatic test_single_corrupt();
    int nreq, ee, ef, lat;
    do_reset();
    run_traffic(1'b0, 3, 19, -1, 1'b0, 1'b0, -1, nreq, ee, ef, lat);
    check_end("single", nreq, ee, ef, ee > 0);
  endtask

  task automatic test_two_corrupt();
    int nreq, ee, ef, lat;
    do_reset();
    run_traffic(1'b0, 3, 40, 5, 1'b0, 1'b0, -1, nreq, ee, ef, lat);
    check_end("two", nreq, ee, ef, ee > 0);
  endtask

  task automatic test_back_to_back();
    int nreq, ee, ef, lat;
    do_reset();
    run_traffic(1'b1, 0, -1, -1, 1'b0, 1'b1, -1, nreq, ee, ef, lat);
    check_end("same_cycle", nreq, ee, ef, ee > 0);
  endtask

  task automatic test_spurious_vld();
    int nreq, ee, ef, lat;
    do_reset();
    run_traffic(1'b0, 3, -1, -1, 1'b1, 1'b0, -1, nreq, ee, ef, lat);
    check_end("spurious", nreq, ee, ef, 1'b1);
  endtask

  task automatic test_random();
    int nreq, ee, ef, lat, b0, b1, al;
    bit same;
    for (int it = 0; it < 3; it++) begin
      b0 = int'($urandom_range(0, TW - 1));
      b1 = int'($urandom_range(0, TW - 1));
      al = int'($urandom_range(0, 4));
      same = 1'($urandom_range(0, 1));
      do_reset();
      run_traffic(same, al, b0, b1, 1'b0, 1'b0, -1, nreq, ee, ef, lat);
      check_end("random", nreq, ee, ef, ee > 0);
    end
  endtask

  task automatic test_reset_mid();
    int nreq, ee, ef, lat;
    do_reset();
    run_traffic(1'b0, 3, 3, -1, 1'b0, 1'b0, 3, nreq, ee, ef, lat);
    run_traffic(1'b0, 2, -1, -1, 1'b0, 1'b0, -1, nreq, ee, ef, lat);
    checks++;
    if (lat != DLY) begin
      $display("FAIL requal_latency: %0d cycles required %0d", lat, DLY);
      errors++;
    end
    check_end("after_reset", nreq, ee, ef, ee > 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ack_no_req();
    test_golden();
    test_single_corrupt();
    test_two_corrupt();
    test_back_to_back();
    test_spurious_vld();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
